// File: rtl/sim_ctrl_pkg.sv
// Shared types and constants for the simulation run controller.
package sim_ctrl_pkg;

    // Controller states: reset hold, executing, and the two terminal states.
    typedef enum logic [1:0] {
        ST_RST_HOLD = 2'd0,
        ST_RUN      = 2'd1,
        ST_HALTED   = 2'd2,
        ST_TIMEOUT  = 2'd3
    } run_state_e;

    // Halt cause encodings as seen on the halt_cause port.
    typedef logic [1:0] halt_cause_t;
    localparam halt_cause_t CAUSE_NONE   = 2'd0;
    localparam halt_cause_t CAUSE_ECALL  = 2'd1;
    localparam halt_cause_t CAUSE_EBREAK = 2'd2;
    localparam halt_cause_t CAUSE_LOOP   = 2'd3;

    // RV32 system instructions that end a program.
    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    // Terminal states only leave on an explicit start pulse.
    function automatic logic is_terminal(input run_state_e s);
        return (s == ST_HALTED) || (s == ST_TIMEOUT);
    endfunction

endpackage

// File: rtl/sim_run_controller_stall_detector.sv
// Self-loop detector: counts consecutive RUN cycles whose PC repeats the
// previous cycle's PC and flags the cycle on which the count reaches the limit.
module stall_detector
    import sim_ctrl_pkg::*;
#(
    parameter int PC_W        = 32,
    parameter int STALL_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [PC_W-1:0] pc,
    output logic            loop_hit
);

    localparam int SC_W = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
    // Counter value that, with one more repeat, reaches the limit.
    localparam logic [SC_W-1:0] LIM_M1 = (STALL_LIMIT > 0) ? SC_W'(STALL_LIMIT - 1) : '0;

    logic [PC_W-1:0] prev_pc_q, prev_pc_d;
    logic            valid_q, valid_d;
    logic [SC_W-1:0] stall_q, stall_d;
    logic            same_pc;

    // The first enabled cycle has no valid previous PC and never counts as a repeat.
    assign same_pc  = valid_q && (pc == prev_pc_q);
    assign loop_hit = en && (STALL_LIMIT != 0) && same_pc && (stall_q == LIM_M1);

    // Next-state: track PC while enabled, forget everything while disabled.
    always_comb begin
        prev_pc_d = prev_pc_q;
        valid_d   = valid_q;
        stall_d   = stall_q;
        if (!en) begin
            valid_d = 1'b0;
            stall_d = '0;
        end else begin
            prev_pc_d = pc;
            valid_d   = 1'b1;
            if (!same_pc)
                stall_d = '0;
            else if (stall_q != LIM_M1)
                stall_d = stall_q + SC_W'(1);
        end
    end

    // State registers with async active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_pc_q <= '0;
            valid_q   <= 1'b0;
            stall_q   <= '0;
        end else begin
            prev_pc_q <= prev_pc_d;
            valid_q   <= valid_d;
            stall_q   <= stall_d;
        end
    end

endmodule

// File: rtl/sim_run_controller.sv
// Run controller: sequences core reset, counts RUN cycles and detects
// end-of-program (ECALL, EBREAK, self-loop, cycle budget timeout).
module sim_run_controller
    import sim_ctrl_pkg::*;
#(
    parameter int PC_W        = 32,
    parameter int INSTR_W     = 32,
    parameter int CNT_W       = 32,
    parameter int RST_CYCLES  = 2,
    parameter int STALL_LIMIT = 4,
    parameter int TIMEOUT     = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instr,
    output logic               core_reset,
    output logic               running,
    output logic               done,
    output logic               timed_out,
    output logic [1:0]         halt_cause,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [PC_W-1:0]    halt_pc
);

    localparam int HC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HC_W-1:0]    HOLD_LAST = HC_W'(RST_CYCLES - 1);
    localparam logic [CNT_W:0]     TO_V      = (CNT_W + 1)'(TIMEOUT);
    localparam logic [INSTR_W-1:0] ECALL_V   = INSTR_W'(INSTR_ECALL);
    localparam logic [INSTR_W-1:0] EBREAK_V  = INSTR_W'(INSTR_EBREAK);

    run_state_e       state_q, state_d;
    logic [HC_W-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    halt_cause_t      cause_q, cause_d;
    logic [PC_W-1:0]  halt_pc_q, halt_pc_d;
    logic             core_reset_q, core_reset_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             timed_out_q, timed_out_d;

    logic             is_ecall, is_ebreak, loop_hit, to_hit;
    logic [CNT_W:0]   cycle_inc;

    stall_detector #(
        .PC_W        (PC_W),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_stall (
        .clk      (clk),
        .reset    (reset),
        .en       (state_q == ST_RUN),
        .pc       (pc),
        .loop_hit (loop_hit)
    );

    assign is_ecall  = (instr == ECALL_V);
    assign is_ebreak = (instr == EBREAK_V);
    // Extra bit so the compare stays exact even when the counter is saturated.
    assign cycle_inc = {1'b0, cycle_q} + {{CNT_W{1'b0}}, 1'b1};
    assign to_hit    = (TIMEOUT != 0) && (cycle_inc == TO_V);

    // Next-state and registered-output decode for the run FSM.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        cycle_d      = cycle_q;
        cause_d      = cause_q;
        halt_pc_d    = halt_pc_q;
        core_reset_d = core_reset_q;
        running_d    = running_q;
        done_d       = done_q;
        timed_out_d  = timed_out_q;
        case (state_q)
            ST_RST_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d      = ST_RUN;
                    hold_d       = '0;
                    core_reset_d = 1'b0;
                    running_d    = 1'b1;
                end else begin
                    hold_d = hold_q + HC_W'(1);
                end
            end
            ST_RUN: begin
                // The halting cycle itself is counted; saturate instead of wrapping.
                if (!(&cycle_q))
                    cycle_d = cycle_q + CNT_W'(1);
                if (is_ecall || is_ebreak || loop_hit) begin
                    state_d   = ST_HALTED;
                    running_d = 1'b0;
                    done_d    = 1'b1;
                    halt_pc_d = pc;
                    if (is_ecall)       cause_d = CAUSE_ECALL;
                    else if (is_ebreak) cause_d = CAUSE_EBREAK;
                    else                cause_d = CAUSE_LOOP;
                end else if (to_hit) begin
                    state_d     = ST_TIMEOUT;
                    running_d   = 1'b0;
                    done_d      = 1'b1;
                    timed_out_d = 1'b1;
                    halt_pc_d   = pc;
                    cause_d     = CAUSE_NONE;
                end
            end
            default: begin
                // Terminal: results frozen until a start pulse re-arms a run.
                if (is_terminal(state_q) && start) begin
                    state_d      = ST_RST_HOLD;
                    hold_d       = '0;
                    cycle_d      = '0;
                    cause_d      = CAUSE_NONE;
                    halt_pc_d    = '0;
                    core_reset_d = 1'b1;
                    running_d    = 1'b0;
                    done_d       = 1'b0;
                    timed_out_d  = 1'b0;
                end
            end
        endcase
    end

    // FSM state, counters and outputs, all cleared asynchronously on reset low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_RST_HOLD;
            hold_q       <= '0;
            cycle_q      <= '0;
            cause_q      <= CAUSE_NONE;
            halt_pc_q    <= '0;
            core_reset_q <= 1'b1;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            timed_out_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            cycle_q      <= cycle_d;
            cause_q      <= cause_d;
            halt_pc_q    <= halt_pc_d;
            core_reset_q <= core_reset_d;
            running_q    <= running_d;
            done_q       <= done_d;
            timed_out_q  <= timed_out_d;
        end
    end

    assign core_reset  = core_reset_q;
    assign running     = running_q;
    assign done        = done_q;
    assign timed_out   = timed_out_q;
    assign halt_cause  = cause_q;
    assign cycle_count = cycle_q;
    assign halt_pc     = halt_pc_q;

endmodule

// File: tb/tb_sim_run_controller.sv
// Directed bench for sim_run_controller: main instance (RST_CYCLES=3,
// STALL_LIMIT=4, TIMEOUT=50) plus a 4-bit counter instance with no timeout.
module tb_sim_run_controller;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [31:0] pc, instr;
    logic        core_reset, running, done, timed_out;
    logic [1:0]  halt_cause;
    logic [31:0] cycle_count, halt_pc;

    logic        rst_s_n;
    logic [31:0] pc_s;
    logic        core_reset_s, running_s, done_s, timed_out_s;
    logic [1:0]  halt_cause_s;
    logic [3:0]  cycle_count_s;
    logic [31:0] halt_pc_s;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sim_run_controller #(
        .PC_W(32), .INSTR_W(32), .CNT_W(32),
        .RST_CYCLES(3), .STALL_LIMIT(4), .TIMEOUT(50)
    ) dut (
        .clk(clk), .reset(rst_n), .start(start), .pc(pc), .instr(instr),
        .core_reset(core_reset), .running(running), .done(done),
        .timed_out(timed_out), .halt_cause(halt_cause),
        .cycle_count(cycle_count), .halt_pc(halt_pc)
    );

    sim_run_controller #(
        .PC_W(32), .INSTR_W(32), .CNT_W(4),
        .RST_CYCLES(2), .STALL_LIMIT(4), .TIMEOUT(0)
    ) dut_s (
        .clk(clk), .reset(rst_s_n), .start(1'b0), .pc(pc_s), .instr(NOP),
        .core_reset(core_reset_s), .running(running_s), .done(done_s),
        .timed_out(timed_out_s), .halt_cause(halt_cause_s),
        .cycle_count(cycle_count_s), .halt_pc(halt_pc_s)
    );

    // Present one RUN cycle's inputs and advance past the sampling edge.
    task automatic step(input logic [31:0] p, input logic [31:0] i);
        pc = p; instr = i;
        @(posedge clk); #1;
    endtask

    // Release reset and check the 3-edge core reset hold on the main instance.
    task automatic release_and_hold(input string tag);
        rst_n = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (core_reset !== (e < 3)) begin
                n_bad++; $display("FAIL %s_core_reset_e%0d got %0b want %0b", tag, e, core_reset, e < 3);
            end
            n_cmp++;
            if (running !== (e == 3)) begin
                n_bad++; $display("FAIL %s_running_e%0d got %0b want %0b", tag, e, running, e == 3);
            end
        end
        n_cmp++;
        if (cycle_count !== 32'd0) begin
            n_bad++; $display("FAIL %s_count0 got %0d want 0", tag, cycle_count);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst_s_n = 1'b0; start = 1'b0; pc = 0; instr = NOP; pc_s = 0;
        #12;
        n_cmp++;
        if ({core_reset, running, done, timed_out, halt_cause} !== 6'b100000) begin
            n_bad++; $display("FAIL reset_outputs got %b want 100000", {core_reset, running, done, timed_out, halt_cause});
        end
        n_cmp++;
        if (cycle_count !== 0 || halt_pc !== 0) begin
            n_bad++; $display("FAIL reset_regs got cnt=%0d pc=%h want 0/0", cycle_count, halt_pc);
        end
        @(posedge clk); #1;
        release_and_hold("por");
    endtask

    // ECALL presented at RUN cycle 10 with pc 0x28.
    task automatic test_ecall();
        for (int k = 0; k < 10; k++) step(32'(4 * k), NOP);
        n_cmp++;
        if (done !== 1'b0 || cycle_count !== 32'd10) begin
            n_bad++; $display("FAIL ecall_pre got done=%0b cnt=%0d want 0/10", done, cycle_count);
        end
        step(32'h28, ECALL);
        n_cmp++;
        if (done !== 1'b1 || running !== 1'b0 || timed_out !== 1'b0) begin
            n_bad++; $display("FAIL ecall_flags got d=%0b r=%0b t=%0b want 1/0/0", done, running, timed_out);
        end
        n_cmp++;
        if (halt_cause !== 2'd1) begin
            n_bad++; $display("FAIL ecall_cause got %0d want 1", halt_cause);
        end
        n_cmp++;
        if (halt_pc !== 32'h28 || cycle_count !== 32'd11) begin
            n_bad++; $display("FAIL ecall_capture got pc=%h cnt=%0d want 28/11", halt_pc, cycle_count);
        end
        // Terminal state holds results while the core keeps going.
        step(32'h2c, NOP);
        step(32'h30, EBREAK);
        n_cmp++;
        if (halt_pc !== 32'h28 || cycle_count !== 32'd11 || halt_cause !== 2'd1 || core_reset !== 1'b0) begin
            n_bad++; $display("FAIL ecall_frozen got pc=%h cnt=%0d cause=%0d cr=%0b want 28/11/1/0", halt_pc, cycle_count, halt_cause, core_reset);
        end
    endtask

    // Start pulse from a terminal state: core reset next edge, then 3-edge hold.
    task automatic test_restart(input string tag);
        start = 1'b1;
        step(32'h0, NOP);
        start = 1'b0;
        n_cmp++;
        if (core_reset !== 1'b1 || done !== 1'b0 || timed_out !== 1'b0) begin
            n_bad++; $display("FAIL %s_start got cr=%0b d=%0b t=%0b want 1/0/0", tag, core_reset, done, timed_out);
        end
        n_cmp++;
        if (cycle_count !== 0 || halt_cause !== 0 || halt_pc !== 0) begin
            n_bad++; $display("FAIL %s_clear got cnt=%0d cause=%0d pc=%h want 0", tag, cycle_count, halt_cause, halt_pc);
        end
        for (int e = 1; e <= 3; e++) begin
            step(32'h0, NOP);
            n_cmp++;
            if (core_reset !== (e < 3) || running !== (e == 3)) begin
                n_bad++; $display("FAIL %s_hold_e%0d got cr=%0b r=%0b want %0b/%0b", tag, e, core_reset, running, e < 3, e == 3);
            end
        end
    endtask

    // EBREAK on the same cycle the self-loop threshold is reached: EBREAK wins.
    task automatic test_ebreak_priority();
        for (int k = 0; k < 4; k++) step(32'h40, NOP);
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++; $display("FAIL prio_pre got done=%0b want 0", done);
        end
        step(32'h40, EBREAK);
        n_cmp++;
        if (done !== 1'b1 || halt_cause !== 2'd2) begin
            n_bad++; $display("FAIL prio_cause got d=%0b cause=%0d want 1/2", done, halt_cause);
        end
        n_cmp++;
        if (cycle_count !== 32'd5 || halt_pc !== 32'h40) begin
            n_bad++; $display("FAIL prio_capture got cnt=%0d pc=%h want 5/40", cycle_count, halt_pc);
        end
    endtask

    // pc held at 0x40 from cycle 5, STALL_LIMIT 4: halt after cycle 9.
    task automatic test_self_loop();
        for (int k = 0; k < 5; k++) step(32'(4 * k), NOP);
        for (int k = 5; k < 9; k++) step(32'h40, NOP);
        n_cmp++;
        if (done !== 1'b0 || running !== 1'b1) begin
            n_bad++; $display("FAIL loop_pre got d=%0b r=%0b want 0/1", done, running);
        end
        step(32'h40, NOP);
        n_cmp++;
        if (done !== 1'b1 || halt_cause !== 2'd3) begin
            n_bad++; $display("FAIL loop_cause got d=%0b cause=%0d want 1/3", done, halt_cause);
        end
        n_cmp++;
        if (cycle_count !== 32'd10 || halt_pc !== 32'h40) begin
            n_bad++; $display("FAIL loop_capture got cnt=%0d pc=%h want 10/40", cycle_count, halt_pc);
        end
    endtask

    // Incrementing pc, no halt, start pulsed mid-run: timeout at exactly 50.
    task automatic test_timeout_and_start_ignored();
        for (int k = 0; k < 49; k++) begin
            start = (k == 20);
            step(32'(4 * k), NOP);
            start = 1'b0;
            if (k == 20) begin
                n_cmp++;
                if (running !== 1'b1 || core_reset !== 1'b0 || cycle_count !== 32'd21) begin
                    n_bad++; $display("FAIL start_in_run got r=%0b cr=%0b cnt=%0d want 1/0/21", running, core_reset, cycle_count);
                end
            end
        end
        n_cmp++;
        if (done !== 1'b0 || cycle_count !== 32'd49) begin
            n_bad++; $display("FAIL timeout_pre got d=%0b cnt=%0d want 0/49", done, cycle_count);
        end
        step(32'(4 * 49), NOP);
        n_cmp++;
        if (timed_out !== 1'b1 || done !== 1'b1 || running !== 1'b0) begin
            n_bad++; $display("FAIL timeout_flags got t=%0b d=%0b r=%0b want 1/1/0", timed_out, done, running);
        end
        n_cmp++;
        if (halt_cause !== 2'd0 || cycle_count !== 32'd50) begin
            n_bad++; $display("FAIL timeout_count got cause=%0d cnt=%0d want 0/50", halt_cause, cycle_count);
        end
    endtask

    // Async reset mid-RUN: outputs return to reset values before any edge.
    task automatic test_async_reset();
        for (int k = 0; k < 6; k++) step(32'(4 * k), NOP);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({core_reset, running, done, timed_out, halt_cause} !== 6'b100000 || cycle_count !== 0) begin
            n_bad++; $display("FAIL async_reset got %b cnt=%0d want 100000/0", {core_reset, running, done, timed_out, halt_cause}, cycle_count);
        end
        @(posedge clk); #1;
        release_and_hold("rerun");
        step(32'h0, ECALL);
        n_cmp++;
        if (done !== 1'b1 || halt_cause !== 2'd1 || cycle_count !== 32'd1) begin
            n_bad++; $display("FAIL rerun_ecall got d=%0b cause=%0d cnt=%0d want 1/1/1", done, halt_cause, cycle_count);
        end
    endtask

    // 4-bit counter, no timeout: saturates at 15 and never finishes.
    task automatic test_saturate();
        @(posedge clk); #1;
        rst_s_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++;
        if (running_s !== 1'b1 || core_reset_s !== 1'b0 || cycle_count_s !== 4'd0) begin
            n_bad++; $display("FAIL sat_start got r=%0b cr=%0b cnt=%0d want 1/0/0", running_s, core_reset_s, cycle_count_s);
        end
        for (int k = 0; k < 15; k++) begin
            pc_s = 32'(4 * k);
            @(posedge clk); #1;
        end
        n_cmp++;
        if (cycle_count_s !== 4'd15) begin
            n_bad++; $display("FAIL sat_reach got %0d want 15", cycle_count_s);
        end
        for (int k = 15; k < 22; k++) begin
            pc_s = 32'(4 * k);
            @(posedge clk); #1;
        end
        n_cmp++;
        if (cycle_count_s !== 4'd15 || done_s !== 1'b0 || running_s !== 1'b1 || timed_out_s !== 1'b0) begin
            n_bad++; $display("FAIL sat_hold got cnt=%0d d=%0b r=%0b t=%0b want 15/0/1/0", cycle_count_s, done_s, running_s, timed_out_s);
        end
    endtask

    initial begin
        test_reset();
        test_ecall();
        test_restart("rs1");
        test_ebreak_priority();
        test_restart("rs2");
        test_self_loop();
        test_restart("rs3");
        test_timeout_and_start_ignored();
        test_restart("rs4");
        test_async_reset();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sim_run_controller.md
# sim_run_controller

Parametrised run controller for processor simulation and bring-up: sequences the core's reset, counts execution cycles, and detects end-of-program. End-of-program is ECALL, EBREAK, a `j .` self-loop, or a cycle-budget timeout. It sits between the clock/reset source and the `RISC_V_Processor` instance. Benches and FPGA wrappers wait on `done` instead of a fixed delay.

## Interface
Parameters:
- `PC_W`, 32: width of the observed PC.
- `INSTR_W`, 32: width of the observed instruction.
- `CNT_W`, 32: width of the cycle counter.
- `RST_CYCLES`, 2: core reset hold length in cycles; must be ≥1.
- `STALL_LIMIT`, 4: number of consecutive unchanged-PC cycles that signals a self-loop; 0 disables loop detection.
- `TIMEOUT`, 1000: RUN-cycle budget; 0 disables the timeout.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that re-arms a new run from a terminal state.
- `pc` in `PC_W`: core's current PC.
- `instr` in `INSTR_W`: core's current fetched instruction.
- `core_reset` out 1: active-high reset to the core.
- `running` out 1: high in RUN.
- `done` out 1: high in HALTED or TIMEOUT.
- `timed_out` out 1: high in TIMEOUT.
- `halt_cause` out 2: 0 none, 1 ECALL, 2 EBREAK, 3 self-loop.
- `cycle_count` out `CNT_W`: number of RUN cycles executed.
- `halt_pc` out `PC_W`: PC captured at the halting cycle.

## Operation
- States are RST_HOLD, RUN, HALTED and TIMEOUT, held in registered state.
- When `reset` is asserted (low), outputs take these values asynchronously:
  - state = RST_HOLD, `core_reset`=1;
  - all counters = 0, `halt_cause`=0, `halt_pc`=0;
  - `running`=`done`=`timed_out`=0.
- RST_HOLD: the hold counter increments each cycle. After `RST_CYCLES` cycles the block enters RUN and `core_reset` drops on that same edge. Deassertion is therefore synchronous to `clk`.
- RUN: `cycle_count` increments once per cycle. It saturates at all-ones and never wraps.
- Halt checks are evaluated combinationally on the `instr` and `pc` inputs each RUN cycle:
  - `instr`==0x00000073 → HALTED, cause 1.
  - `instr`==0x00100073 → HALTED, cause 2.
  - `pc` equal to the previous RUN cycle's `pc`:
    - increments the stall counter; any change clears it;
    - the first RUN cycle has no previous PC and never counts;
    - when the stall counter reaches `STALL_LIMIT` → HALTED, cause 3.
  - `cycle_count`+1 reaching `TIMEOUT` with no halt → TIMEOUT, cause 0.
- Priority when several conditions hold in the same cycle: ECALL > EBREAK > self-loop > timeout.
- The halting cycle is counted. `halt_pc` takes that cycle's `pc`.
- HALTED and TIMEOUT are terminal:
  - `cycle_count`, `halt_cause` and `halt_pc` are frozen;
  - `core_reset` stays 0;
  - the core keeps running; the wrapper gates it if needed.
- `start`=1 in HALTED or TIMEOUT → RST_HOLD: `core_reset`=1, and counters, cause and `halt_pc` are cleared.
- `start` in RST_HOLD or RUN is ignored.
- All outputs are registered or decoded from registered state only; there are no combinational paths from input to output.

## Timing
- After `reset` goes high: `core_reset` stays high for exactly `RST_CYCLES` rising edges. `running` rises on the same edge that `core_reset` falls.
- Halt latency is 1 cycle: `done` is high on the edge after the cycle in which the halting `instr`/`pc` was presented.
- A self-loop entered at RUN cycle k (`pc` first repeats at cycle k+1) gives `done` after cycle k+`STALL_LIMIT`. `cycle_count` then equals k+`STALL_LIMIT`+1 (0-based k).
- With no halt, TIMEOUT is entered with `cycle_count`==`TIMEOUT` exactly.
- `start` → `core_reset` high on the next edge, then the same RST_HOLD sequence as after reset.
- An async `reset` mid-RUN or mid-hold aborts immediately and behaves as a power-on reset.

## Structure
- A shared package `sim_ctrl_pkg` holds:
  - the state enum;
  - the `halt_cause` encodings;
  - the `ECALL`/`EBREAK` instruction constants.
- The single sub-module `stall_detector` contains the previous-PC register, the valid flag, and a stall counter sized $clog2(`STALL_LIMIT`+1). It is enabled by RUN and outputs `loop_hit`.
- The FSM, cycle counter and capture registers stay in the top module.

## Test plan
- Reset with `RST_CYCLES`=3 → `core_reset` high for exactly 3 edges after `reset` rises. `running` rises on the third edge. `cycle_count`=0 at that point.
- Drive `instr`=0x00000073 at RUN cycle 10 with `pc`=0x28 → `done`=1 next edge, `halt_cause`=1, `halt_pc`=0x28, `cycle_count`=11.
- Same cycle `instr`=0x00100073 and `pc` repeating at stall threshold → `halt_cause`=2. Loop detection alone with `STALL_LIMIT`=4, `pc` held at 0x40 from cycle 5 → `halt_cause`=3, `cycle_count`=10.
- Incrementing `pc`, `TIMEOUT`=50 → `timed_out`=1, `halt_cause`=0, `cycle_count`=50. A `start` pulse → `core_reset`=1 next edge, count 0, new run proceeds.
- `start` pulsed during RUN → ignored. Async `reset` low mid-RUN → all outputs return to reset values without waiting for a clock edge.
- `TIMEOUT`=0, `CNT_W`=4, free-running `pc` → `cycle_count` saturates at 15, no wrap, `done`=0.
